// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults for the FIFO control slice: geometry, thresholds and level-update encoding.
package fifo_ctrl_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH = 3;
    localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;
    localparam int unsigned FIFO_AF_THRESH  = 6;
    localparam int unsigned FIFO_AE_THRESH  = 2;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    // Classify the accepted strobes into a single level update.
    function automatic lvl_op_e lvl_op(input logic we, input logic re);
        lvl_op_e op;
        op = LVL_HOLD;
        if (we && !re) begin
            op = LVL_INC;
        end else if (re && !we) begin
            op = LVL_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address pointer with enable; wraps naturally modulo 2**WIDTH.
module fifo_ptr #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: gates requests into RAM strobes, tracks pointers, occupancy and
// status flags (flags registered from the next level so they line up with level).
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int unsigned AF_THRESH  = FIFO_AF_THRESH,
    parameter int unsigned AE_THRESH  = FIFO_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic                  rd_req,
    input  logic                  err_clr,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned LW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH:0] level_nxt;
    lvl_op_e             op;

    // Strobes depend only on registered flags, so no read-to-write bypass exists.
    assign wr_en = wr_req & ~full  & ~reset;
    assign rd_en = rd_req & ~empty & ~reset;

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (wr_en),
        .ptr   (wr_addr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (rd_en),
        .ptr   (rd_addr)
    );

    always_comb begin
        level_nxt = level;
        op        = lvl_op(wr_en, rd_en);
        case (op)
            LVL_INC: level_nxt = level + LW'(1);
            LVL_DEC: level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            level        <= level_nxt;
            full         <= (level_nxt == LW'(DEPTH));
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= LW'(AF_THRESH));
            almost_empty <= (level_nxt <= LW'(AE_THRESH));
            // A fresh error in the same cycle as a clear keeps the flag set.
            if (wr_req && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: occupancy model compared every cycle plus directed pins.
module tb_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       err_clr = 1'b0;
    logic       wr_en, rd_en;
    logic [2:0] wr_addr, rd_addr;
    logic [3:0] level;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: occupancy count, pointers as plain integers, sticky bits.
    int m_level = 0;
    int m_w     = 0;
    int m_r     = 0;
    bit m_ovf   = 0;
    bit m_unf   = 0;
    bit chk_on  = 0;

    fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .err_clr      (err_clr),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Every cycle: outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("wr_en", int'(wr_en), int'(wr_req && !reset && m_level < DEPTH));
            chk("rd_en", int'(rd_en), int'(rd_req && !reset && m_level > 0));
            chk("wr_addr", int'(wr_addr), m_w);
            chk("rd_addr", int'(rd_addr), m_r);
            chk("level", int'(level), m_level);
            chk("full", int'(full), int'(m_level == DEPTH));
            chk("empty", int'(empty), int'(m_level == 0));
            chk("almost_full", int'(almost_full), int'(m_level >= AF));
            chk("almost_empty", int'(almost_empty), int'(m_level <= AE));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_unf));
        end
    end

    task automatic model_edge(input bit wr, input bit rd, input bit clr, input bit rst);
        int  we, re;
        if (rst) begin
            m_level = 0; m_w = 0; m_r = 0; m_ovf = 0; m_unf = 0;
        end else begin
            we = (wr && m_level < DEPTH) ? 1 : 0;
            re = (rd && m_level > 0) ? 1 : 0;
            if (wr && m_level == DEPTH) m_ovf = 1;
            else if (clr)               m_ovf = 0;
            if (rd && m_level == 0)     m_unf = 1;
            else if (clr)               m_unf = 0;
            m_level = m_level + we - re;
            m_w = (m_w + we) % DEPTH;
            m_r = (m_r + re) % DEPTH;
        end
    endtask

    task automatic cyc(input bit wr, input bit rd, input bit clr, input bit rst);
        wr_req = wr; rd_req = rd; err_clr = clr; reset = rst;
        @(posedge clk);
        model_edge(wr, rd, clr, rst);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 1);
        chk_on = 1;
        cyc(0, 0, 0, 1);
        chk("pin_reset_level", int'(level), 0);
        chk("pin_reset_empty", int'(empty), 1);
        chk("pin_reset_ae", int'(almost_empty), 1);

        // Fill to full, then one extra write.
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 0, 0);
            if (i == 5) chk("pin_af_before6", int'(almost_full), 0);
            if (i == 6) chk("pin_af_at6", int'(almost_full), 1);
        end
        chk("pin_full_level", int'(level), 8);
        chk("pin_full", int'(full), 1);
        chk("pin_wr_wrap", int'(wr_addr), 0);
        cyc(1, 0, 0, 0);
        chk("pin_overflow", int'(overflow), 1);
        chk("pin_level_hold8", int'(level), 8);

        // Clear collides with a new overflow: flag must stay set.
        cyc(1, 0, 1, 0);
        chk("pin_set_wins", int'(overflow), 1);
        cyc(0, 0, 1, 0);
        chk("pin_ovf_clr", int'(overflow), 0);

        // Full with both requests: read only.
        cyc(1, 1, 0, 0);
        chk("pin_full_both_level", int'(level), 7);
        chk("pin_full_both_ovf", int'(overflow), 1);
        chk("pin_full_both_rd", int'(rd_addr), 1);

        // Drain, then empty with both requests: write only.
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
        chk("pin_drained", int'(empty), 1);
        cyc(0, 1, 0, 0);
        chk("pin_underflow", int'(underflow), 1);
        cyc(1, 1, 0, 0);
        chk("pin_empty_both_level", int'(level), 1);
        cyc(0, 0, 1, 0);
        chk("pin_unf_clr", int'(underflow), 0);
        chk("pin_ovf_clr2", int'(overflow), 0);

        // Reset mid-operation at level 5 with a write pending.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        chk("pin_level5", int'(level), 5);
        cyc(1, 0, 0, 1);
        chk("pin_rst_level", int'(level), 0);
        chk("pin_rst_wptr", int'(wr_addr), 0);
        chk("pin_rst_rptr", int'(rd_addr), 0);

        // Level 4 then 20 cycles of simultaneous traffic.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0);
        chk("pin_stream_level", int'(level), 4);
        chk("pin_stream_wptr", int'(wr_addr), 0);
        chk("pin_stream_rptr", int'(rd_addr), 4);

        // Randomized traffic with drifting write/read bias.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 300) % 2 == 0 ? 70 : 30;
            cyc(($urandom_range(99) < bias),
                ($urandom_range(99) < 100 - bias),
                ($urandom_range(15) == 0),
                ($urandom_range(127) == 0));
        end

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
